bpu_resolve: RTL and testbench
==============================

Name: bpu_resolve

Overview:
- Execute-stage partner of the branch prediction unit: it closes the predictor's feedback loop.
- Keeps an in-order queue of predictions issued at fetch and pops one when execute resolves a branch/JAL.
- Compares predicted vs actual outcome; drives the flush/redirect to the PC and pipeline control logic.
- Drives the registered training feedback (last_jump/last_addr/last_need_predict) back to the predictor, plus saturating performance counters.

Parameters:
- DEPTH, 4, prediction queue entries (power of two, >=2).
- AW, 32, instruction address width.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pred_valid_i  in  1  fetch issues a prediction for a B-type/JAL instruction this cycle.
- pred_pc_i  in  AW  PC of predicted instruction.
- pred_taken_i  in  1  predicted direction.
- pred_target_i  in  AW  predicted target (don't-care if not taken).
- pred_ready_o  out  1  queue not full.
- res_valid_i  in  1  execute resolves a branch/JAL this cycle.
- res_pc_i  in  AW  PC of resolved instruction.
- res_taken_i  in  1  actual direction.
- res_target_i  in  AW  actual taken target.
- flush_i  in  1  external flush (trap/interrupt); clears queue.
- mispredict_o  out  1  one-cycle pulse: redirect fetch, flush younger instructions.
- redirect_addr_o  out  AW  correct next PC; valid when mispredict_o=1.
- last_need_predict_o  out  1  one-cycle pulse: predictor state update strobe.
- last_jump_o  out  1  actual direction for the update.
- last_addr_o  out  AW  PC for the update.
- branch_cnt_o  out  CNT_W  resolved branch count.
- miss_cnt_o  out  CNT_W  mispredict count.

Behaviour:
- Reset (async, rst=1): queue empty (wr/rd pointers 0, count 0); all outputs 0 except pred_ready_o=1; counters 0. Reset mid-operation discards all in-flight entries immediately.
- Queue: circular FIFO; pointers log2(DEPTH) bits wrap modulo DEPTH; count is 0..DEPTH. pred_ready_o = (count != DEPTH), combinational from count.
- Push: on pred_valid_i & pred_ready_o. Push while full is ignored (entry lost, no error). Push while empty is allowed.
- Pop: on res_valid_i when the queue is non-empty and head.pc == res_pc_i ("hit"). Same-cycle push+pop when full is legal; count is unchanged.
- Miss: res_valid_i with the queue empty or a head PC mismatch. Treated as predicted not-taken with no target; nothing is popped; the queue is cleared (desync recovery).
- Mispredict decision, for hit and miss cases:
  - Direction mismatch, or both taken and head.target != res_target_i.
  - Not taken in both: never a mispredict, target ignored.
- Redirect address: res_taken_i ? res_target_i : res_pc_i + 4, computed modulo 2^AW (wraps, no carry out).
- Latency: all outputs registered; they are asserted the cycle after res_valid_i. mispredict_o, last_need_predict_o: single-cycle pulses.
- Mispredict clear: on the resolving edge, the queue is cleared (pointers and count to 0) and any same-cycle push is dropped.
- Training: every res_valid_i produces last_need_predict_o=1 next cycle, with last_jump_o=res_taken_i and last_addr_o=res_pc_i. This holds regardless of hit/miss or mispredict. last_jump_o/last_addr_o hold their values between pulses.
- Counters: branch_cnt_o +1 per res_valid_i; miss_cnt_o +1 per mispredict. Both saturate at all-ones, no wrap.
- flush_i: clears the queue on that edge; same-cycle push dropped.
- flush_i with same-cycle res_valid_i: resolution still evaluated and fed back (training, counters, mispredict/redirect as computed); flush takes priority for queue contents.
- res_valid_i consecutive cycles allowed; each resolution is independent. The second resolution sees the queue state after the first.

Test Plan:
- Push (pc=0x100,T,0x80); resolve (0x100,T,0x80) next cycle -> mispredict_o=0; last_need_predict_o=1, last_jump_o=1, last_addr_o=0x100; branch_cnt_o=1, miss_cnt_o=0; count back to 0.
- Push (0x200,NT); resolve (0x200,T,0x240) -> mispredict_o=1, redirect_addr_o=0x240 one cycle later; miss_cnt_o=1.
- Push (0x300,T,0x400), then (0x304,T,0x500); resolve 0x300 taken with target 0x410 -> mispredict_o=1, redirect=0x410, queue empty, 0x304 entry discarded.
- Fill 4 entries -> pred_ready_o=0, 5th push ignored.
- Full queue, same-cycle push and hit-pop -> count stays 4, and the new entry is popped 4th in order.
- Empty queue, resolve (0xFFFFFFFC, NT) -> no mispredict, last_need_predict_o=1. Then resolve (0x10, T, 0x20) -> mispredict_o=1, redirect=0x20. Confirm NT redirect computation wraps: res_pc=0xFFFFFFFC, NT, forced mismatch via queued T entry -> redirect=0x00000000.
- Assert rst mid-stream with 3 entries queued -> outputs 0 and pred_ready_o=1 immediately, without waiting for a clock edge. Preload counters to all-ones, then one more resolution -> counters stay all-ones.

Source files
------------

// File: rtl/bpu_resolve.sv
// Execute-side branch resolution: in-order prediction queue, mispredict/redirect
// generation, registered predictor training feedback and saturating perf counters.
module bpu_resolve #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid_i,
  input  logic [AW-1:0]    pred_pc_i,
  input  logic             pred_taken_i,
  input  logic [AW-1:0]    pred_target_i,
  output logic             pred_ready_o,
  input  logic             res_valid_i,
  input  logic [AW-1:0]    res_pc_i,
  input  logic             res_taken_i,
  input  logic [AW-1:0]    res_target_i,
  input  logic             flush_i,
  output logic             mispredict_o,
  output logic [AW-1:0]    redirect_addr_o,
  output logic             last_need_predict_o,
  output logic             last_jump_o,
  output logic [AW-1:0]    last_addr_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [AW-1:0]    r_pc  [DEPTH];
  logic [AW-1:0]    r_tgt [DEPTH];
  logic [DEPTH-1:0] r_tk;
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [PW:0]      r_count;

  logic             r_mis, r_lnp, r_jump;
  logic [AW-1:0]    r_redir, r_addr;
  logic [CNT_W-1:0] r_branch_cnt, r_miss_cnt;

  logic          w_full, w_empty, w_hit, w_pred_taken, w_mis, w_clear, w_pop, w_push;
  logic [AW-1:0] w_pred_target;

  assign w_full  = (r_count == (PW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_hit   = res_valid_i & ~w_empty & (r_pc[r_rd_ptr] == res_pc_i);

  // A queue miss is treated as a not-taken prediction with no target.
  assign w_pred_taken  = w_hit & r_tk[r_rd_ptr];
  assign w_pred_target = r_tgt[r_rd_ptr];
  assign w_mis = res_valid_i & ((w_pred_taken != res_taken_i) |
                 (w_pred_taken & res_taken_i & (w_pred_target != res_target_i)));

  assign w_clear = flush_i | (res_valid_i & ~w_hit) | w_mis;
  assign w_pop   = w_hit & ~w_clear;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_push  = pred_valid_i & (~w_full | w_pop) & ~w_clear;

  assign pred_ready_o = ~w_full;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_wr_ptr]  <= pred_pc_i;
      r_tgt[r_wr_ptr] <= pred_target_i;
      r_tk[r_wr_ptr]  <= pred_taken_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mis        <= 1'b0;
      r_lnp        <= 1'b0;
      r_jump       <= 1'b0;
      r_redir      <= '0;
      r_addr       <= '0;
      r_branch_cnt <= '0;
      r_miss_cnt   <= '0;
    end else begin
      r_mis <= w_mis;
      r_lnp <= res_valid_i;
      if (res_valid_i) begin
        r_jump  <= res_taken_i;
        r_addr  <= res_pc_i;
        r_redir <= res_taken_i ? res_target_i : res_pc_i + AW'(4);
        if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + 1'b1;
      end
      if (w_mis && r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
    end
  end

  assign mispredict_o        = r_mis;
  assign redirect_addr_o     = r_redir;
  assign last_need_predict_o = r_lnp;
  assign last_jump_o         = r_jump;
  assign last_addr_o         = r_addr;
  assign branch_cnt_o        = r_branch_cnt;
  assign miss_cnt_o          = r_miss_cnt;

endmodule

// File: tb/tb_bpu_resolve.sv
// Scoreboard bench for bpu_resolve: stimulus queues expected feedback, a negedge
// monitor pops and compares whenever the training strobe appears.
module tb_bpu_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid_i, pred_taken_i, res_valid_i, res_taken_i, flush_i;
  logic [31:0] pred_pc_i, pred_target_i, res_pc_i, res_target_i;
  logic        pred_ready_o, mispredict_o, last_need_predict_o, last_jump_o;
  logic [31:0] redirect_addr_o, last_addr_o;
  logic [3:0]  branch_cnt_o, miss_cnt_o;

  bpu_resolve #(.DEPTH(4), .AW(32), .CNT_W(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .pred_valid_i        (pred_valid_i),
    .pred_pc_i           (pred_pc_i),
    .pred_taken_i        (pred_taken_i),
    .pred_target_i       (pred_target_i),
    .pred_ready_o        (pred_ready_o),
    .res_valid_i         (res_valid_i),
    .res_pc_i            (res_pc_i),
    .res_taken_i         (res_taken_i),
    .res_target_i        (res_target_i),
    .flush_i             (flush_i),
    .mispredict_o        (mispredict_o),
    .redirect_addr_o     (redirect_addr_o),
    .last_need_predict_o (last_need_predict_o),
    .last_jump_o         (last_jump_o),
    .last_addr_o         (last_addr_o),
    .branch_cnt_o        (branch_cnt_o),
    .miss_cnt_o          (miss_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        mis;
    logic [31:0] redir;
    logic        jump;
    logic [31:0] addr;
    logic [3:0]  br;
    logic [3:0]  miss;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [3:0] exp_br = '0;
  logic [3:0] exp_miss = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        exp_t e;
        e = sbq.pop_front();
        chk("need_predict_pulse", 64'(last_need_predict_o), 64'(1'b1));
        chk("mispredict", 64'(mispredict_o), 64'(e.mis));
        if (e.mis) chk("redirect_addr", 64'(redirect_addr_o), 64'(e.redir));
        chk("last_jump", 64'(last_jump_o), 64'(e.jump));
        chk("last_addr", 64'(last_addr_o), 64'(e.addr));
        chk("branch_cnt", 64'(branch_cnt_o), 64'(e.br));
        chk("miss_cnt", 64'(miss_cnt_o), 64'(e.miss));
      end else begin
        chk("unexpected_pulse", 64'(last_need_predict_o), 64'(1'b0));
        chk("mispredict_idle", 64'(mispredict_o), 64'(1'b0));
      end
    end
  end

  // Entered and left at posedge+1; inputs captured on the next rising edge.
  task automatic cycle(input logic pv, input logic [31:0] ppc, input logic pt,
                       input logic [31:0] ptgt, input logic rv, input logic [31:0] rpc,
                       input logic rt, input logic [31:0] rtgt, input logic fl,
                       input logic emis, input logic [31:0] eredir);
    pred_valid_i  = pv;  pred_pc_i  = ppc; pred_taken_i = pt; pred_target_i = ptgt;
    res_valid_i   = rv;  res_pc_i   = rpc; res_taken_i  = rt; res_target_i  = rtgt;
    flush_i       = fl;
    if (rv) begin
      exp_t e;
      if (exp_br != 4'hF) exp_br++;
      if (emis && exp_miss != 4'hF) exp_miss++;
      e.due = cyc + 1; e.mis = emis; e.redir = eredir; e.jump = rt; e.addr = rpc;
      e.br = exp_br; e.miss = exp_miss;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    pred_valid_i = 1'b0; res_valid_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    cycle(1'b1, pc, t, tgt, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic resolve(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                         input logic emis, input logic [31:0] eredir);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, pc, t, tgt, 1'b0, emis, eredir);
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(pred_ready_o), 64'(1'b1));
    chk({tag, "_mispredict"}, 64'(mispredict_o), 64'(1'b0));
    chk({tag, "_redirect"}, 64'(redirect_addr_o), 64'(0));
    chk({tag, "_need_predict"}, 64'(last_need_predict_o), 64'(1'b0));
    chk({tag, "_jump"}, 64'(last_jump_o), 64'(1'b0));
    chk({tag, "_addr"}, 64'(last_addr_o), 64'(0));
    chk({tag, "_branch_cnt"}, 64'(branch_cnt_o), 64'(0));
    chk({tag, "_miss_cnt"}, 64'(miss_cnt_o), 64'(0));
  endtask

  initial begin
    rst = 1'b1;
    pred_valid_i = 1'b0; pred_pc_i = '0; pred_taken_i = 1'b0; pred_target_i = '0;
    res_valid_i  = 1'b0; res_pc_i  = '0; res_taken_i  = 1'b0; res_target_i  = '0;
    flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    idle();

    // Correct taken prediction
    push(32'h100, 1'b1, 32'h80);
    resolve(32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    chk("ready_after_pop", 64'(pred_ready_o), 64'(1'b1));

    // Direction mispredict
    push(32'h200, 1'b0, 32'h0);
    resolve(32'h200, 1'b1, 32'h240, 1'b1, 32'h240);

    // Target mispredict discards the younger entry
    push(32'h300, 1'b1, 32'h400);
    push(32'h304, 1'b1, 32'h500);
    resolve(32'h300, 1'b1, 32'h410, 1'b1, 32'h410);
    resolve(32'h304, 1'b1, 32'h500, 1'b1, 32'h500);

    // Fill, overflow push, then push+pop while full
    for (int i = 0; i < 4; i++) push(32'h1000 + 32'(4 * i), 1'b0, 32'h0);
    chk("ready_full", 64'(pred_ready_o), 64'(1'b0));
    push(32'h1010, 1'b0, 32'h0);
    chk("ready_full_after_drop", 64'(pred_ready_o), 64'(1'b0));
    cycle(1'b1, 32'h1020, 1'b1, 32'h2000, 1'b1, 32'h1000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("ready_full_push_pop", 64'(pred_ready_o), 64'(1'b0));
    resolve(32'h1004, 1'b0, 32'h0, 1'b0, 32'h0);
    resolve(32'h1008, 1'b0, 32'h0, 1'b0, 32'h0);
    resolve(32'h100C, 1'b0, 32'h0, 1'b0, 32'h0);
    resolve(32'h1020, 1'b1, 32'h2000, 1'b0, 32'h0);
    chk("ready_drained", 64'(pred_ready_o), 64'(1'b1));

    // Empty-queue resolutions and PC+4 wrap
    resolve(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
    resolve(32'h10, 1'b1, 32'h20, 1'b1, 32'h20);
    push(32'hFFFF_FFFC, 1'b1, 32'h40);
    resolve(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0);

    // Flush clears queue and drops same-cycle push
    push(32'h500, 1'b1, 32'h600);
    cycle(1'b1, 32'h504, 1'b1, 32'h700, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    resolve(32'h500, 1'b1, 32'h600, 1'b1, 32'h600);
    push(32'h700, 1'b1, 32'h710);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h700, 1'b1, 32'h710, 1'b1, 1'b0, 32'h0);

    // Drive both counters into saturation
    for (int i = 0; i < 12; i++) resolve(32'h2000 + 32'(4 * i), 1'b1, 32'h3000, 1'b1, 32'h3000);
    idle();

    // Asynchronous reset with three entries left in flight
    push(32'h900, 1'b0, 32'h0);
    push(32'h904, 1'b1, 32'h950);
    push(32'h908, 1'b0, 32'h0);
    push(32'h90C, 1'b0, 32'h0);
    res_valid_i = 1'b1; res_pc_i = 32'h900; res_taken_i = 1'b0; res_target_i = '0;
    @(posedge clk); #1;
    res_valid_i = 1'b0;
    #1 rst = 1'b1;
    #1 chk_reset_outputs("async_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    exp_br = '0; exp_miss = '0;
    resolve(32'h904, 1'b1, 32'h950, 1'b1, 32'h950);
    idle();
    idle();
    chk("scoreboard_drained", 64'(sbq.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
